// File: rtl/regs_dump_pkg.sv
// Shared types and constants for the picoMIPS register-file dump reader.
package regs_dump_pkg;

    // Dump sequencer states
    typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} dump_state_t;

    localparam int NREGS  = 32;
    localparam int ADDR_W = 5;

endpackage : regs_dump_pkg

// File: rtl/regs_dump.sv
// regs_dump: debug reader that walks the register file through the shared
// Raddr1/Rdata1 port and streams (addr, data) pairs over valid/ready while
// holding the CPU stalled.
// Build option: define REGS_DUMP_SKIP_ZERO_EN to start the walk at %1
// instead of %0 (the hard-wired zero register is then never fetched).
module regs_dump
    import regs_dump_pkg::*;
#(
    parameter int n        = 8,
    parameter int LAST_REG = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] Raddr,
    input  logic [n-1:0]      Rdata,
    output logic [n-1:0]      dout,
    output logic [ADDR_W-1:0] daddr,
    output logic              dvalid,
    input  logic              dready,
    output logic              hold,
    output logic              done
);

`ifdef REGS_DUMP_SKIP_ZERO_EN
    localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(1);
`else
    localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(0);
`endif
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(LAST_REG);

    dump_state_t       state_q;
    logic [ADDR_W-1:0] raddr_q;
    logic [n-1:0]      dout_q;
    logic [ADDR_W-1:0] daddr_q;
    logic              dvalid_q;
    logic              hold_q;
    logic              done_q;

    // Dump sequencer: every output is a register updated here
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            raddr_q  <= '0;
            dout_q   <= '0;
            daddr_q  <= '0;
            dvalid_q <= 1'b0;
            hold_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        raddr_q <= FIRST;
                        hold_q  <= 1'b1;
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    // regs read is combinational, so Rdata already matches raddr_q
                    dout_q   <= Rdata;
                    daddr_q  <= raddr_q;
                    dvalid_q <= 1'b1;
                    state_q  <= SEND;
                end
                SEND: begin
                    if (dready) begin
                        dvalid_q <= 1'b0;
                        if (raddr_q == LAST_A) begin
                            state_q <= DONE;
                        end else begin
                            raddr_q <= raddr_q + ADDR_W'(1);
                            state_q <= FETCH;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    hold_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Raddr  = raddr_q;
    assign dout   = dout_q;
    assign daddr  = daddr_q;
    assign dvalid = dvalid_q;
    assign hold   = hold_q;
    assign done   = done_q;

endmodule : regs_dump
